div_seq: RTL and testbench

//  Multi-cycle sequencer for DIV/DIVU in the EX stage of the MIPS pipeline.

---
 rtl/div_seq_if.sv | 26 ++
 rtl/div_seq.sv | 141 ++++++++++++++
 tb/tb_div_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// EX-stage divide sequencer bus: decoder-side request and HI/LO write-back.
// Latency: not applicable; this is a pure signal bundle.
// Backpressure: stall_o from the sequencer holds the requesting pipeline.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic [7:0]         op_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               cancel_i;
  logic               stall_o;
  logic [2*WIDTH-1:0] result_o;
  logic               hilo_we_o;

  // Pipeline side: issues the ALU code and operands and watches stall/write-back.
  modport master (
    output op_i, a_i, b_i, cancel_i,
    input  stall_o, result_o, hilo_we_o
  );

  // Divider side.
  modport slave (
    input  op_i, a_i, b_i, cancel_i,
    output stall_o, result_o, hilo_we_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: radix-2 restoring divider with a pipeline stall and a HI/LO strobe.
// Latency: WIDTH+1 stall cycles, with the strobe in cycle WIDTH+2; a zero divisor gives 2 stall cycles, then the strobe.
// Backpressure: stall_o holds IF/ID/EX while a divide runs; cancel_i aborts at once and drops stall.
module div_seq #(
  parameter int         WIDTH   = 32,
  parameter int         CNT_W   = 6,
  parameter logic [7:0] DIV_OP  = 8'b0001_1010,
  parameter logic [7:0] DIVU_OP = 8'b0001_1011
) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_rem;     // partial remainder
  logic [WIDTH-1:0]     r_quo;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]     r_div;     // divisor magnitude
  logic                 r_neg_q;   // quotient gets negated at the end
  logic                 r_neg_r;   // remainder gets negated at the end (dividend was negative)
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_is_div;
  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_sub;
  logic [WIDTH-1:0]     w_rem_step;
  logic [WIDTH-1:0]     w_quo_step;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_zero_rem;
  logic                 w_last;
  logic                 w_stall;
  logic                 w_we;

  assign w_is_div = (bus.op_i == DIV_OP) | (bus.op_i == DIVU_OP);
  assign w_signed = (bus.op_i == DIV_OP);
  assign w_a_neg  = w_signed & bus.a_i[WIDTH-1];
  assign w_b_neg  = w_signed & bus.b_i[WIDTH-1];
  // The magnitude of the most negative value is its own bit pattern read as unsigned.
  assign w_a_mag  = w_a_neg ? (~bus.a_i + 1'b1) : bus.a_i;
  assign w_b_mag  = w_b_neg ? (~bus.b_i + 1'b1) : bus.b_i;

  // One restoring step: bring the next dividend bit into the remainder, then subtract if it fits.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_sub      = w_shift - {1'b0, r_div};
  assign w_rem_step = w_sub[WIDTH] ? w_shift[WIDTH-1:0] : w_sub[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], ~w_sub[WIDTH]};

  // Apply the signs to the step output so the final step writes the finished result directly.
  assign w_quo_fix  = r_neg_q ? (~w_quo_step + 1'b1) : w_quo_step;
  assign w_rem_fix  = r_neg_r ? (~w_rem_step + 1'b1) : w_rem_step;
  // A zero divisor returns the original dividend, rebuilt from its latched magnitude.
  assign w_zero_rem = r_neg_r ? (~r_quo + 1'b1) : r_quo;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state, stall and strobe; cancel overrides everything else in any state.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_we    = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_is_div;
        if (w_is_div) w_next = (bus.b_i == '0) ? ZERO : BUSY;
      end
      BUSY: begin
        w_stall = 1'b1;
        if (w_last) w_next = DONE;
      end
      ZERO: begin
        w_stall = 1'b1;
        w_next  = DONE;
      end
      DONE: begin
        w_we   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (bus.cancel_i) begin
      w_next  = IDLE;
      w_stall = 1'b0;
      w_we    = 1'b0;
    end
  end

  // Datapath: latch operands on start, iterate in BUSY, and capture the result on the way into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_div && !bus.cancel_i) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
          end
        end
        BUSY: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_result <= {w_rem_fix, w_quo_fix};
        end
        ZERO: r_result <= {w_zero_rem, {WIDTH{1'b1}}};
        default: ;
      endcase
    end
  end

  assign bus.stall_o   = w_stall;
  assign bus.hilo_we_o = w_we;
  assign bus.result_o  = r_result;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with a scoreboard-checked HI/LO write-back.
// Latency: checks stall length and strobe cycle per divide.
// Backpressure: holds the divide code while stall_o is high, as the pipeline would.
module tb_div_seq;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
  localparam logic [7:0] OP_MULT = 8'b0001_1000;
  localparam logic [7:0] OP_ADD  = 8'b0010_0000;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;

  logic [63:0] exp_q[$];
  int          strobe_cyc[$];

  div_seq_if #(.WIDTH(32)) bus();

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every strobe must match the oldest pending expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.hilo_we_o === 1'b1) begin
        strobe_cyc.push_back(cyc_cnt);
        chk("strobe_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("result", bus.result_o, exp_q.pop_front());
      end
    end
  end

  // Issue a divide, hold it while stalled, scramble operands after the first cycle.
  task automatic do_div(input string name, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_stall);
    int n_stall = 0;
    int cyc = 0;
    bit seen = 0;
    exp_q.push_back(exp);
    bus.op_i = op;
    bus.a_i  = a;
    bus.b_i  = b;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.stall_o) n_stall++;
      if (bus.hilo_we_o) seen = 1;
      @(posedge clk);
      #1;
      bus.a_i = 32'hA5A5_0000 + 32'(cyc);
      bus.b_i = 32'h0000_0003 ^ 32'(cyc);
    end
    chk({name, "_stall_cycles"}, 64'(n_stall), 64'(exp_stall));
    chk({name, "_strobe_cycle"}, 64'(cyc), 64'(exp_stall + 1));
    bus.op_i = OP_NOP;
  endtask

  // Start a divide, abort it in cycle 'at' by cancel or reset, then watch for silence.
  task automatic do_abort(input string name, input logic [31:0] a, input int at, input bit use_rst);
    int n_stall = 0;
    int n_we = 0;
    bus.op_i = OP_DIVU;
    bus.a_i  = a;
    bus.b_i  = 32'd3;
    for (int c = 1; c < at; c++) begin
      @(negedge clk);
      if (bus.stall_o) n_stall++;
      @(posedge clk);
      #1;
    end
    chk({name, "_stall_before"}, 64'(n_stall), 64'(at - 1));
    if (use_rst) rst = 1'b1;
    else bus.cancel_i = 1'b1;
    @(negedge clk);
    if (!use_rst) chk({name, "_stall_at_cancel"}, 64'(bus.stall_o), 64'd0);
    if (!use_rst) chk({name, "_we_at_cancel"}, 64'(bus.hilo_we_o), 64'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.cancel_i = 1'b0;
    bus.op_i     = OP_NOP;
    n_stall      = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.stall_o) n_stall++;
      if (bus.hilo_we_o) n_we++;
      @(posedge clk);
      #1;
    end
    chk({name, "_stall_after"}, 64'(n_stall), 64'd0);
    chk({name, "_we_after"}, 64'(n_we), 64'd0);
  endtask

  initial begin
    logic [7:0] ops[4];
    int n_stall;
    int n_we;
    int base;
    ops[0] = OP_MULT;
    ops[1] = OP_ADD;
    ops[2] = OP_MFLO;
    ops[3] = OP_MFHI;

    bus.op_i     = OP_NOP;
    bus.a_i      = '0;
    bus.b_i      = '0;
    bus.cancel_i = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 64'(bus.stall_o), 64'd0);
    chk("reset_we", 64'(bus.hilo_we_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    @(posedge clk);
    #1;

    // Unsigned and signed divides, including sign combinations and the overflow wrap.
    do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    do_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    do_div("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
    do_div("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 33);
    do_div("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33);

    // Zero divisor.
    do_div("div_5_0", OP_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 2);

    // Aborts: cancel mid-divide, reset mid-divide, cancel in the strobe cycle.
    do_abort("cancel_busy", 32'd1000, 11, 1'b0);
    do_div("after_cancel", OP_DIVU, 32'd50, 32'd8, {32'd2, 32'd6}, 33);
    do_abort("rst_busy", 32'd1000, 11, 1'b1);
    do_div("after_rst", OP_DIVU, 32'd7, 32'd7, {32'd0, 32'd1}, 33);
    do_abort("cancel_done", 32'd1000, 34, 1'b0);

    // Back-to-back divides with no gap between them.
    base = strobe_cyc.size();
    do_div("b2b_20_3", OP_DIVU, 32'd20, 32'd3, {32'd2, 32'd6}, 33);
    do_div("b2b_9_4", OP_DIVU, 32'd9, 32'd4, {32'd1, 32'd2}, 33);
    chk("b2b_strobe_count", 64'(strobe_cyc.size() - base), 64'd2);
    if (strobe_cyc.size() >= base + 2)
      chk("b2b_spacing", 64'(strobe_cyc[base + 1] - strobe_cyc[base]), 64'd34);

    // Non-divide codes never stall or strobe.
    n_stall = 0;
    n_we    = 0;
    for (int i = 0; i < 24; i++) begin
      bus.op_i = ops[i % 4];
      bus.a_i  = $urandom;
      bus.b_i  = (i % 3 == 0) ? 32'd0 : $urandom;
      @(negedge clk);
      if (bus.stall_o) n_stall++;
      if (bus.hilo_we_o) n_we++;
      @(posedge clk);
      #1;
    end
    bus.op_i = OP_NOP;
    chk("nondiv_stall", 64'(n_stall), 64'd0);
    chk("nondiv_we", 64'(n_we), 64'd0);

    repeat (3) @(posedge clk);
    chk("leftover_expected", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
